// File: rtl/barrel_shifter_pipe.sv
`timescale 1ns/1ps
// Pipelined barrel shifter/rotator: one registered stage per amount bit,
// valid/ready handshake with full backpressure, sideband tag pass-through.
module barrel_shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amt,
  input  logic             in_lr,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    amt;   // remaining amount bits, LSB applies at this stage
    logic             lr;
    logic [1:0]       mode;
    logic             fill;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t st  [AW];
  stage_t nxt [AW];
  stage_t head;
  logic   en;
  logic   zero_q;

  // Shift/rotate d by s positions; only mode 10 rotates, fill only matters going right.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d, input logic lr,
                                                  input logic [1:0] mode, input logic fill,
                                                  input int unsigned s);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    ones = '1;
    if (mode == 2'b10)
      r = lr ? ((d >> s) | (d << (WIDTH - s))) : ((d << s) | (d >> (WIDTH - s)));
    else if (lr)
      r = (d >> s) | (fill ? ~(ones >> s) : '0);
    else
      r = d << s;
    return r;
  endfunction

  // One pipeline step: apply 2^k when the current amount LSB is set, then retire that bit.
  function automatic stage_t step(input stage_t s, input int unsigned k);
    stage_t r;
    r = s;
    if (s.amt[0])
      r.data = shift_step(s.data, s.lr, s.mode, s.fill, 32'd1 << k);
    r.amt = s.amt >> 1;
    return r;
  endfunction

  assign en        = !st[AW-1].valid || out_ready;
  assign in_ready  = en;
  assign out_valid = st[AW-1].valid;
  assign out_data  = st[AW-1].data;
  assign out_tag   = st[AW-1].tag;
  assign out_zero  = zero_q;

  // Capture the incoming beat; the fill bit is fixed here for the whole trip.
  always_comb begin
    head       = '0;
    head.valid = in_valid;
    head.data  = in_data;
    head.amt   = in_amt;
    head.lr    = in_lr;
    head.mode  = in_mode;
    head.fill  = (in_mode == 2'b01) && in_lr && in_data[WIDTH-1];
    head.tag   = in_tag;
  end

  // Next value of every stage, bubbles included.
  always_comb begin
    nxt[0] = step(head, 0);
    for (int unsigned k = 1; k < AW; k++)
      nxt[k] = step(st[k-1], k);
  end

  // Stage registers advance together under the global enable; reset flushes everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < AW; k++)
        st[k] <= '0;
      zero_q <= 1'b0;
    end else if (en) begin
      for (int unsigned k = 0; k < AW; k++)
        st[k] <= nxt[k];
      zero_q <= (nxt[AW-1].data == '0);
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
`timescale 1ns/1ps
// Bench for barrel_shifter_pipe: a 16-bit and a 32-bit instance, scoreboard queues,
// table vectors plus stall, reset and random-backpressure sequences.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        a_iv, a_ir, a_lr, a_ov, a_or, a_oz;
  logic [15:0] a_id, a_od;
  logic [3:0]  a_amt, a_it, a_ot;
  logic [1:0]  a_mode;

  logic        b_iv, b_ir, b_lr, b_ov, b_or, b_oz;
  logic [31:0] b_id, b_od;
  logic [4:0]  b_amt;
  logic [3:0]  b_it, b_ot;
  logic [1:0]  b_mode;

  barrel_shifter_pipe #(.WIDTH(16), .TAG_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .in_amt(a_amt), .in_lr(a_lr), .in_mode(a_mode), .in_tag(a_it), .out_valid(a_ov),
    .out_ready(a_or), .out_data(a_od), .out_tag(a_ot), .out_zero(a_oz));

  barrel_shifter_pipe #(.WIDTH(32), .TAG_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .in_amt(b_amt), .in_lr(b_lr), .in_mode(b_mode), .in_tag(b_it), .out_valid(b_ov),
    .out_ready(b_or), .out_data(b_od), .out_tag(b_ot), .out_zero(b_oz));

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        zero;
    int unsigned cyc;
    bit          lat;
  } exp_t;

  typedef struct {
    int unsigned w;
    logic [31:0] d;
    int unsigned amt;
    logic        lr;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  bit          stall_prev [2];
  logic [31:0] prev_d [2];
  logic [3:0]  prev_t [2];
  bit          rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Bit-by-bit reference: result bit i taken from its source position.
  function automatic logic [31:0] model(input int unsigned w, input logic [31:0] d,
                                        input int unsigned amt, input logic lr, input logic [1:0] mode);
    logic [31:0] r;
    logic        fill;
    int unsigned src;
    r = '0;
    fill = (mode == 2'b01 && lr) ? d[w-1] : 1'b0;
    for (int unsigned i = 0; i < w; i++) begin
      if (mode == 2'b10) begin
        src = lr ? (i + amt) % w : (i + w - amt) % w;
        r[i] = d[src];
      end else if (lr) begin
        src = i + amt;
        r[i] = (src < w) ? d[src] : fill;
      end else begin
        r[i] = (i >= amt) ? d[i-amt] : 1'b0;
      end
    end
    return r;
  endfunction

  // Called just after a negedge: present the beat, hold until accepted, push the expectation.
  task automatic send(input int unsigned w, input logic [31:0] d, input int unsigned amt,
                      input logic lr, input logic [1:0] mode, input logic [3:0] tag,
                      input logic [31:0] exp, input bit lat);
    exp_t        e;
    int unsigned guard = 0;
    if (w == 0) begin
      a_iv = 1'b1; a_id = d[15:0]; a_amt = amt[3:0]; a_lr = lr; a_mode = mode; a_it = tag;
    end else begin
      b_iv = 1'b1; b_id = d; b_amt = amt[4:0]; b_lr = lr; b_mode = mode; b_it = tag;
    end
    #1;
    while (!((w == 0) ? a_ir : b_ir)) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 200) begin
        n_vec++; n_err++;
        $display("FAIL accept timeout d%0d: in_ready stayed 0, required 1 within 200 cycles", w);
        a_iv = 1'b0; b_iv = 1'b0;
        return;
      end
    end
    e.data = exp;
    e.tag  = tag;
    e.zero = (w == 0) ? (exp[15:0] == 16'h0) : (exp == 32'h0);
    e.cyc  = cyc;
    e.lat  = lat;
    if (w == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    if (w == 0) a_iv = 1'b0; else b_iv = 1'b0;
  endtask

  task automatic mon_check(input int unsigned w, input logic ov, input logic ordy,
                           input logic [31:0] od, input logic [3:0] ot, input logic oz);
    exp_t e;
    bool_empty: begin end
    if (stall_prev[w]) begin
      check($sformatf("stall valid d%0d", w), {31'h0, ov}, 32'h1);
      check($sformatf("stall data d%0d", w), od, prev_d[w]);
      check($sformatf("stall tag d%0d", w), {28'h0, ot}, {28'h0, prev_t[w]});
    end
    stall_prev[w] = ov && !ordy;
    prev_d[w] = od;
    prev_t[w] = ot;
    if (ov && ordy) begin
      if (((w == 0) ? q0.size() : q1.size()) == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected d%0d: got data %h tag %h, required no output", w, od, ot);
      end else begin
        e = (w == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("data d%0d tag%0d", w, e.tag), od, e.data);
        check($sformatf("tag d%0d", w), {28'h0, ot}, {28'h0, e.tag});
        check($sformatf("zero d%0d tag%0d", w, e.tag), {31'h0, oz}, {31'h0, e.zero});
        if (e.lat)
          check($sformatf("latency d%0d tag%0d", w, e.tag), cyc - e.cyc, (w == 0) ? 32'd4 : 32'd5);
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    mon_check(0, a_ov, a_or, {16'h0, a_od}, a_ot, a_oz);
    mon_check(1, b_ov, b_or, b_od, b_ot, b_oz);
  end

  task automatic drain();
    int unsigned g = 0;
    while ((q0.size() != 0 || q1.size() != 0) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("drain outstanding", q0.size() + q1.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  vec_t vt[$];

  initial begin
    reset_n = 1'b0;
    a_iv = 0; a_id = '0; a_amt = '0; a_lr = 0; a_mode = '0; a_it = '0; a_or = 1'b1;
    b_iv = 0; b_id = '0; b_amt = '0; b_lr = 0; b_mode = '0; b_it = '0; b_or = 1'b1;
    stall_prev[0] = 0; stall_prev[1] = 0;

    vt.push_back('{0, 32'h2465, 4, 1'b1, 2'b00, 32'h0246});
    vt.push_back('{0, 32'h2465, 4, 1'b0, 2'b00, 32'h4650});
    vt.push_back('{0, 32'h2465, 4, 1'b1, 2'b10, 32'h5246});
    vt.push_back('{0, 32'h2465, 4, 1'b0, 2'b10, 32'h4652});
    vt.push_back('{0, 32'h8001, 15, 1'b1, 2'b01, 32'hFFFF});
    vt.push_back('{0, 32'h4001, 1, 1'b1, 2'b01, 32'h2000});
    vt.push_back('{0, 32'h8001, 1, 1'b0, 2'b01, 32'h0002});
    vt.push_back('{0, 32'h0001, 1, 1'b1, 2'b00, 32'h0000});
    vt.push_back('{0, 32'h8001, 1, 1'b1, 2'b11, 32'h4000});
    vt.push_back('{0, 32'h9ABC, 0, 1'b1, 2'b01, 32'h9ABC});
    vt.push_back('{1, 32'h4AE22465, 31, 1'b1, 2'b10, 32'h95C448CA});
    vt.push_back('{1, 32'h00000001, 31, 1'b0, 2'b00, 32'h80000000});
    vt.push_back('{1, 32'h80000000, 31, 1'b1, 2'b01, 32'hFFFFFFFF});
    vt.push_back('{1, 32'hDEADBEEF, 0, 1'b0, 2'b10, 32'hDEADBEEF});

    repeat (3) @(negedge clk);
    check("reset out_valid a", {31'h0, a_ov}, 32'h0);
    check("reset out_data a", {16'h0, a_od}, 32'h0);
    check("reset out_tag a", {28'h0, a_ot}, 32'h0);
    check("reset out_zero a", {31'h0, a_oz}, 32'h0);
    check("reset out_valid b", {31'h0, b_ov}, 32'h0);
    check("reset out_data b", b_od, 32'h0);
    reset_n = 1'b1;
    #1;
    check("post-reset in_ready a", {31'h0, a_ir}, 32'h1);
    check("post-reset in_ready b", {31'h0, b_ir}, 32'h1);
    @(negedge clk);

    // Directed table, one beat at a time with latency checking.
    for (int i = 0; i < vt.size(); i++) begin
      send(vt[i].w, vt[i].d, vt[i].amt, vt[i].lr, vt[i].mode, 4'(i), vt[i].exp, 1'b1);
      drain();
    end

    // Back-to-back sweeps: rotate right on 16 bits, arithmetic right on 32 bits.
    for (int unsigned amt = 0; amt < 16; amt++)
      send(0, 32'h2465, amt, 1'b1, 2'b10, 4'(amt), model(16, 32'h2465, amt, 1'b1, 2'b10), 1'b1);
    drain();
    for (int unsigned amt = 0; amt < 32; amt++)
      send(1, 32'h8F001234, amt, 1'b1, 2'b01, 4'(amt), model(32, 32'h8F001234, amt, 1'b1, 2'b01), 1'b1);
    drain();

    // Backpressure mid-stream: out_ready low for 3 cycles while a result is waiting.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(0, 32'hA5C3 ^ (32'h1111 * i), i + 1, (i % 2) == 1, 2'(i % 3), 4'(8 + i),
               model(16, 32'hA5C3 ^ (32'h1111 * i), i + 1, (i % 2) == 1, 2'(i % 3)), 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        a_or = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #1;
          check("stall in_ready", {31'h0, a_ir}, 32'h0);
          @(negedge clk);
        end
        a_or = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight: they must vanish.
    for (int i = 0; i < 3; i++)
      send(0, 32'h00F0, 1, 1'b0, 2'b00, 4'(i), 32'h01E0, 1'b0);
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    stall_prev[0] = 0; stall_prev[1] = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("flush out_valid", {31'h0, a_ov}, 32'h0);
    check("flush in_ready", {31'h0, a_ir}, 32'h1);
    repeat (8) @(negedge clk);
    send(0, 32'h1234, 8, 1'b1, 2'b10, 4'hD, 32'h3412, 1'b1);
    drain();

    // Random traffic with random backpressure on each instance.
    for (int unsigned w = 0; w < 2; w++) begin
      rnd_done = 1'b0;
      fork
        begin
          for (int i = 0; i < 40; i++) begin
            logic [31:0] d;
            int unsigned amt;
            logic lr;
            logic [1:0] mode;
            d = $urandom;
            if (w == 0) d[31:16] = '0;
            amt = $urandom_range(0, (w == 0) ? 15 : 31);
            lr = 1'($urandom_range(0, 1));
            mode = 2'($urandom_range(0, 3));
            send(w, d, amt, lr, mode, 4'(i), model((w == 0) ? 16 : 32, d, amt, lr, mode), 1'b0);
          end
          rnd_done = 1'b1;
        end
        begin
          while (!rnd_done) begin
            @(negedge clk);
            if (w == 0) a_or = ($urandom_range(0, 3) != 0);
            else        b_or = ($urandom_range(0, 3) != 0);
          end
        end
      join
      a_or = 1'b1;
      b_or = 1'b1;
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
